clkdiv_monitor: RTL and testbench

- Measures a divided clock produced by the team's clock divider and checks it, all in the divider's own clk domain.
- Counts clk cycles between rising edges of div_in (period) and cycles div_in stays high (high time).
- Compares the period against an expected ratio and reports mismatch, lock and timeout status.
- Used in lab builds and benches to confirm each divider output runs at its programmed ratio.

---
 rtl/clkdiv_mon_pkg.sv | 12 +
 rtl/clkdiv_monitor_edge_detect.sv | 27 ++
 rtl/clkdiv_monitor.sv | 128 ++++++++++++
 tb/tb_clkdiv_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_mon_pkg.sv
// Shared types and default sizing for the divided-clock monitor.
package clkdiv_mon_pkg;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_LOCK_COUNT = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/clkdiv_monitor_edge_detect.sv
// Two-stage sampler of the divided clock with rise/fall strobes.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s0,
    output logic rise_c,
    output logic fall_c
);

    logic s1;

    // Sample the divided clock and keep one cycle of history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= din;
            s1 <= s0;
        end
    end

    assign rise_c = s0 & ~s1;
    assign fall_c = ~s0 & s1;

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures period and high time of a divided clock and reports mismatch/lock/timeout.
module clkdiv_monitor
    import clkdiv_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [7:0]       tol,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             mismatch,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned DIFF_W = CNT_W + 1;
    localparam int unsigned CMP_W  = CNT_W + 9;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

    state_t             state;
    logic [CNT_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   hi_cnt;
    logic [CNT_W-1:0]   hi_lat;
    logic [GOOD_W-1:0]  good_cnt;

    logic               s0;
    logic               rise_c;
    logic               fall_c;

    logic [DIFF_W-1:0]  diff_c;
    logic [DIFF_W-1:0]  abs_diff_c;
    logic               mismatch_c;
    logic [GOOD_W-1:0]  good_inc_c;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .din    (div_in),
        .s0     (s0),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Deviation of the running period count from the expected period.
    always_comb begin
        diff_c     = DIFF_W'(per_cnt) - DIFF_W'(exp_period);
        abs_diff_c = diff_c;
        if (diff_c[DIFF_W-1]) begin
            abs_diff_c = DIFF_W'(0) - diff_c;
        end
        mismatch_c = (exp_period != '0) && (CMP_W'(abs_diff_c) > CMP_W'(tol));
        good_inc_c = good_cnt + GOOD_W'(1);
    end

    // Measurement FSM: first rise arms, each later rise publishes a result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            hi_lat     <= '0;
            good_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (fall_c) begin
                hi_lat <= hi_cnt;
            end
            case (state)
                IDLE: begin
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                    if (rise_c) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_c) begin
                        period     <= per_cnt;
                        high_time  <= hi_lat;
                        meas_valid <= 1'b1;
                        mismatch   <= mismatch_c;
                        per_cnt    <= CNT_W'(1);
                        hi_cnt     <= CNT_W'(1);
                        if (mismatch_c) begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end else if (good_cnt == GOOD_MAX) begin
                            locked <= 1'b1;
                        end else begin
                            good_cnt <= good_inc_c;
                            locked   <= (good_inc_c == GOOD_MAX);
                        end
                    end else if (per_cnt == CNT_MAX) begin
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        per_cnt  <= '0;
                        hi_cnt   <= '0;
                        state    <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        if (s0) begin
                            hi_cnt <= hi_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Randomized and directed bench for clkdiv_monitor with an index-based reference model.
module tb_clkdiv_monitor;

    localparam int unsigned CW = 8;
    localparam int LOCKN = 4;
    localparam int MAXC  = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          div_in = 1'b0;
    logic [CW-1:0] exp_period = '0;
    logic [7:0]    tol = '0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          mismatch;
    logic          locked;
    logic          timeout;

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;

    // Reference model state: sample history and rise/fall sample indices.
    bit h1 = 0, h2 = 0, armed = 0;
    int k = 0, rise_idx = 0, fall_idx = 0, good = 0;
    int m_period = 0, m_high = 0, m_valid = 0, m_mis = 0, m_locked = 0, m_timeout = 0;

    always #5 clk = ~clk;

    clkdiv_monitor #(.CNT_W(CW), .LOCK_COUNT(LOCKN)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_in     (div_in),
        .exp_period (exp_period),
        .tol        (tol),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .mismatch   (mismatch),
        .locked     (locked),
        .timeout    (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: a rise at sample i is seen by the DUT one cycle later; results appear the cycle after that.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            h1 = 0; h2 = 0; armed = 0; k = 0; rise_idx = 0; fall_idx = 0; good = 0;
            m_period = 0; m_high = 0; m_valid = 0; m_mis = 0; m_locked = 0; m_timeout = 0;
        end else begin
            int ev;
            int d;
            ev = k - 1;
            m_valid = 0;
            if (h1 && !h2) begin
                if (armed) begin
                    m_period = ev - rise_idx;
                    m_high   = fall_idx - rise_idx;
                    m_valid  = 1;
                    d = m_period - int'(exp_period);
                    if (d < 0) d = -d;
                    m_mis = (exp_period != 0 && d > int'(tol)) ? 1 : 0;
                    if (m_mis != 0) good = 0;
                    else if (good < LOCKN) good++;
                    m_locked = (good == LOCKN) ? 1 : 0;
                end else begin
                    armed = 1;
                    m_timeout = 0;
                end
                rise_idx = ev;
            end else if (armed && (ev - rise_idx == MAXC)) begin
                armed = 0;
                m_timeout = 1;
                good = 0;
                m_locked = 0;
            end
            if (!h1 && h2) fall_idx = ev;
            h2 = h1;
            h1 = div_in;
            k++;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cmp_period", period, m_period);
        check("cmp_high_time", high_time, m_high);
        check("cmp_meas_valid", meas_valid, m_valid);
        check("cmp_mismatch", mismatch, m_mis);
        check("cmp_locked", locked, m_locked);
        check("cmp_timeout", timeout, m_timeout);
        if (meas_valid === 1'b1) valid_seen++;
    end

    task automatic run_div(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                div_in = (c < h);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        div_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;

        // Divide by 2, exact expectation.
        exp_period = 8'd2; tol = 8'd0;
        run_div(2, 1, 8); settle();
        check("t1_period", period, 2);
        check("t1_high", high_time, 1);
        check("t1_mismatch", mismatch, 0);
        check("t1_locked", locked, 1);

        // Divide by 16, 50% duty.
        exp_period = 8'd16;
        run_div(16, 8, 7); settle();
        check("t2_period", period, 16);
        check("t2_high", high_time, 8);
        check("t2_locked", locked, 1);
        check("t2_model_period", m_period, 16);

        // Divide by 8, 25% duty, check disabled.
        exp_period = 8'd0;
        run_div(8, 2, 6); settle();
        check("t3_period", period, 8);
        check("t3_high", high_time, 2);
        check("t3_mismatch", mismatch, 0);
        check("t3_locked", locked, 1);

        // Period 10 against 8 with tolerance 1, then 2.
        exp_period = 8'd8; tol = 8'd1;
        run_div(10, 5, 5); settle();
        check("t4_period", period, 10);
        check("t4_mismatch", mismatch, 1);
        check("t4_locked", locked, 0);
        tol = 8'd2;
        run_div(10, 5, 3); settle();
        check("t4_tol2_mismatch", mismatch, 0);
        check("t4_tol2_period", period, 10);
        check("t4_model_mis", m_mis, 0);

        // Lock then stop the clock: timeout, then two rises to recover.
        exp_period = 8'd16; tol = 8'd0;
        run_div(16, 8, 7); settle();
        check("t5_locked_before", locked, 1);
        repeat (300) @(negedge clk);
        check("t5_timeout", timeout, 1);
        check("t5_locked_after", locked, 0);
        check("t5_period_kept", period, 16);
        v0 = valid_seen;
        run_div(16, 8, 1);
        check("t5_timeout_cleared", timeout, 0);
        check("t5_no_valid_first_rise", valid_seen - v0, 0);
        run_div(16, 8, 1); settle();
        check("t5_valid_second_rise", valid_seen - v0, 1);
        check("t5_period_recovered", period, 16);

        // Asynchronous reset mid-period.
        run_div(16, 8, 3);
        repeat (4) begin @(negedge clk); div_in = 1'b1; end
        #2 reset = 1'b0; div_in = 1'b0;
        #1;
        check("t6_async_period", period, 0);
        check("t6_async_high", high_time, 0);
        check("t6_async_locked", locked, 0);
        check("t6_async_mismatch", mismatch, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        v0 = valid_seen;
        run_div(16, 8, 1);
        check("t6_no_valid_first_rise", valid_seen - v0, 0);
        run_div(16, 8, 1); settle();
        check("t6_valid_second_rise", valid_seen - v0, 1);
        check("t6_period", period, 16);

        // Randomized ratios, duties, expectations and occasional stalls.
        for (int it = 0; it < 30; it++) begin
            int p;
            int h;
            int e;
            p = int'($urandom_range(2, 40));
            h = int'($urandom_range(1, p - 1));
            if ($urandom_range(0, 3) == 0) e = 0;
            else begin
                e = p + int'($urandom_range(0, 6)) - 3;
                if (e < 1) e = 1;
            end
            exp_period = CW'(e);
            tol = 8'($urandom_range(0, 3));
            run_div(p, h, int'($urandom_range(2, 6)));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); div_in = 1'b0;
                repeat (260) @(negedge clk);
            end
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
